// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM state encoding and a helper
// that sizes the nibble counter.
package nibble_add_pkg;

  // Adder slice width. Fixed: the datapath is built around a 4-bit ripple-carry slice.
  localparam int unsigned NIB = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StAdd  = S_ADD,
    StDone = S_DONE
  } state_e;

  // Counter width for num_nib nibbles; never narrower than one bit so WIDTH=4 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned num_nib);
    int unsigned w;
    w = $clog2(num_nib);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Handshake and data bundle of the nibble-serial adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : operation in progress
// master = producer/consumer around the adder, slave = the adder itself.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry adder built from full-adder equations.
//   a, b : addend nibbles
//   cin  : carry in
//   sum  : a + b + cin (low 4 bits)
//   cout : carry out of bit 3
module add4_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that processes one nibble per cycle through a single 4-bit slice.
// The inter-nibble carry is registered and the result is assembled LSB-first into a shift
// register filled from the MSB end.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : operand/result handshakes (slave side), see nibble_serial_adder_if
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus_io
);

  localparam int unsigned NUM_NIB = WIDTH / NIB;
  localparam int unsigned CntW    = cnt_width(NUM_NIB);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NIB-1:0]    slice_sum;
  logic              slice_cout;
  logic              last_nib;

  add4_slice u_slice (
    .a    (a_sh_q[NIB-1:0]),
    .b    (b_sh_q[NIB-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_nib = (cnt_q == CntW'(NUM_NIB - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_sh_d  = bus_io.a;
          b_sh_d  = bus_io.b;
          carry_d = bus_io.cin;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end

      StAdd: begin
        // Shift-based form keeps WIDTH == NIB legal (no zero-width slices).
        res_d   = (res_q >> NIB) | (WIDTH'(slice_sum) << (WIDTH - NIB));
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> NIB;
        b_sh_d  = b_sh_q >> NIB;
        cnt_d   = cnt_q + CntW'(1);
        if (last_nib) begin
          // Output registers load only on entry to DONE so they stay put under backpressure.
          sum_d   = res_d;
          cout_d  = slice_cout;
          state_d = StDone;
        end
      end

      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases, mid-operation reset, randomized
// back-to-back traffic against an arithmetic reference, and a WIDTH=4 instance.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, carry is bit 16.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge after the output handshake.
  // keep=1 leaves in_valid high with the next operands presented during ADD/DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int stall, input bit keep,
                        input logic [15:0] na, input logic [15:0] nb, input logic nc);
    logic [16:0] exp;
    int n;
    exp = ref_add(a, b, c);
    check_eq("in_ready_before", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    if (keep) begin
      bus.a   = na;
      bus.b   = nb;
      bus.cin = nc;
    end else begin
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.cin      = 1'($urandom);
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check_eq("busy_in_add", 32'(bus.busy), 32'd1);
      check_eq("in_ready_in_add", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'd4);
    check_eq("sum", 32'(bus.sum), 32'(exp[15:0]));
    check_eq("cout", 32'(bus.cout), 32'(exp[16]));
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("stall_sum", 32'(bus.sum), 32'(exp[15:0]));
      check_eq("stall_cout", 32'(bus.cout), 32'(exp[16]));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("post_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("post_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("post_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [3:0]  a4, b4;
    logic        c4;
    logic [4:0]  e4;
    int          n;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus.out_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.out_ready = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_sum", 32'(bus.sum), 32'h0);
    check_eq("idle_cout", 32'(bus.cout), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    // Directed adds
    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, '0, '0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, '0, '0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, 1'b0, '0, '0, 1'b0);

    // Backpressure for 10 cycles with the next request already pending
    run_op(16'hABCD, 16'h1111, 1'b0, 10, 1'b1, 16'h0F0F, 16'h7070, 1'b1);
    run_op(16'h0F0F, 16'h7070, 1'b1, 0, 1'b0, '0, '0, 1'b0);

    // Reset on the second ADD cycle aborts the operation
    bus.a        = 16'h00FF;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_sum", 32'(bus.sum), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_hold_out_valid", 32'(bus.out_valid), 32'd0);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_eq("after_abort_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("after_abort_in_ready", 32'(bus.in_ready), 32'd1);
    end
    run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0, '0, '0, 1'b0);

    // Randomized back-to-back traffic
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0);
    end

    // WIDTH=4 instance: one ADD cycle
    for (int k = 0; k < 17; k++) begin
      if (k == 0) begin
        a4 = 4'h9;
        b4 = 4'h8;
        c4 = 1'b0;
      end else begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        c4 = 1'($urandom);
      end
      e4 = {1'b0, a4} + {1'b0, b4} + 5'(c4);
      check_eq("w4_in_ready", 32'(bus4.in_ready), 32'd1);
      bus4.a        = a4;
      bus4.b        = b4;
      bus4.cin      = c4;
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("w4_latency", 32'(n), 32'd1);
      check_eq("w4_sum", 32'(bus4.sum), 32'(e4[3:0]));
      check_eq("w4_cout", 32'(bus4.cout), 32'(e4[4]));
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;
      check_eq("w4_post_out_valid", 32'(bus4.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder. It adds WIDTH-bit operands four bits at a time through one 4-bit ripple-carry adder slice.
- The carry is registered between nibbles, and the result is assembled in a shift register.
- It sits directly around the team's 4-bit adder stage:
  - Upstream side: it feeds that stage one operand nibble pair and the carry-in each cycle.
  - Downstream side: it consumes the stage's sum/cout.
- Valid/ready handshakes on the input and output sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, 4, adder slice width; fixed at 4 and not overridable in use.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b and cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into the least-significant nibble.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of the most-significant nibble.
- busy  out  1  high in ADD or DONE.

Behaviour:
- Reset (async, rst=1), immediately and while asserted:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0.
  - Internal carry, nibble counter and operand shift registers are cleared.
- NUM_NIB = WIDTH/4.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b into the shift registers, set carry<=cin, cnt<=0, go to ADD.
  - Values on a/b/cin after acceptance are ignored.
- ADD: in_ready=0. Each cycle:
  - The slice computes a_sh[3:0] + b_sh[3:0] + carry.
  - The slice sum is shifted into res from the MSB end (res <= {slice_sum, res[WIDTH-1:4]}).
  - carry <= slice_cout.
  - a_sh and b_sh shift right by 4.
  - cnt increments.
  - On the edge where cnt == NUM_NIB-1, go to DONE.
- DONE:
  - out_valid=1.
  - sum=res, cout=carry; both held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops.
- Latency: out_valid rises NUM_NIB clock edges after the input-acceptance edge (16-bit: 4 edges).
- Minimum issue interval: NUM_NIB+2 cycles. There is no overlap, and in_ready is low in ADD and DONE.
- out_ready in IDLE or ADD has no effect. in_valid in ADD or DONE is ignored and not queued.
- sum/cout outputs are registers. They change only on:
  - entry to DONE (valid data), or
  - reset (cleared to 0).
- Contents of sum/cout outside DONE are don't-care to consumers but must be deterministic.
- Overflow: sum wraps modulo 2^WIDTH. The overflow carry appears only on cout; there is no signed-overflow flag.
- Reset mid-operation (in ADD or DONE) aborts the operation. There is no out_valid pulse for the aborted operation. The block returns to IDLE with in_ready=1 on the first edge after rst deasserts.
- WIDTH=4 degenerate case: a single ADD cycle, then DONE.

Decomposition:
- Package nibble_add_pkg:
  - State encoding localparams S_IDLE=2'd0, S_ADD=2'd1, S_DONE=2'd2.
  - NIB=4.
  - Function to compute counter width, $clog2(NUM_NIB) clamped to a minimum of 1.
- One sub-module, add4_slice: combinational 4-bit ripple-carry adder built from full-adder equations.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Instantiated once.
  - It must not share a module name with the existing 4-bit adder.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset and idle: hold rst=1 for 3 cycles, then release → in_ready=1, out_valid=0, sum=0x0000, cout=0, busy=0.
- Basic add: a=0x1234, b=0x4321, cin=1, in_valid pulse for 1 cycle → exactly 4 edges later out_valid=1, sum=0x5556, cout=0. Then assert out_ready → out_valid=0 and in_ready=1 next cycle.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- Backpressure and ignored input: out_ready=0 for 10 cycles in DONE → out_valid stays 1, sum/cout stable. A new in_valid presented during ADD/DONE is not accepted (in_ready=0); it is accepted the cycle after the output handshake.
- Reset mid-operation: assert rst on the 2nd ADD cycle of a=0x00FF, b=0x0001 → out_valid never rises for it. After release, a=0x0003, b=0x0004, cin=0 → sum=0x0007, cout=0.
- Randomized back-to-back run: 1000 random a/b/cin with random out_ready, compared against a reference model {cout,sum} = a+b+cin. Also repeat the basic add with WIDTH=4: a=0x9, b=0x8, cin=0 → sum=0x1, cout=1 after 1 edge.
